// File: rtl/rdata_handler_pkg.sv
// Shared types and constants for the read-side job handler.
package rdata_handler_pkg;

  localparam int SYS_ARRAY_SIZE = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int ROW_BITS       = SYS_ARRAY_SIZE * DATA_WIDTH;
  localparam int ROW_BYTES      = ROW_BITS / 8;
  localparam int ADDR_WIDTH     = 16;

  // Largest DRAIN_CYCLES value the shared counter type can hold.
  localparam int DRAIN_MAX      = 8 * SYS_ARRAY_SIZE;
  localparam int CNT_WIDTH      = $clog2(DRAIN_MAX);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ROW_BITS-1:0]   row_t;
  typedef logic [CNT_WIDTH-1:0]  countn_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    WB    = 2'd3
  } rd_state_t;

  // Address of row idx of a matrix stored from base; wraps silently.
  function automatic addr_t row_addr(addr_t base, countn_t idx);
    return base + addr_t'(idx) * addr_t'(ROW_BYTES);
  endfunction

endpackage

// File: rtl/rdata_handler_skew_buffer.sv
// Triangular delay line: lane i delays its input by i cycles. When bubble
// is high the lane inputs are replaced by zero so empty slots carry 0.
module skew_buffer #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bubble,
  input  logic [LANES-1:0][WIDTH-1:0]  din,
  output logic [LANES-1:0][WIDTH-1:0]  dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] lane_in;

    // Zero-fill the lane whenever no fetched data is present.
    assign lane_in = bubble ? '0 : din[i];

    if (i == 0) begin : g_pass
      assign dout[i] = lane_in;
    end else begin : g_delay
      logic [WIDTH-1:0] pipe [i];

      // Shift chain of i registers for lane i.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < i; j++) pipe[j] <= '0;
        end else begin
          pipe[0] <= lane_in;
          for (int j = 1; j < i; j++) pipe[j] <= pipe[j-1];
        end
      end

      assign dout[i] = pipe[i-1];
    end
  end

endmodule

// File: rtl/rdata_handler.sv
// Read-side job sequencer: fetches N rows of A and B, skews them onto the
// systolic array edges, waits for the array to drain, then hands the C
// base address to the write handler while the array shifts results out.
//
// state | meaning
// IDLE  | ready for a job, latches bases on start_i
// FETCH | N cycles of A/B row reads, clear on the first
// DRAIN | DRAIN_CYCLES cycles waiting for array results to settle
// WB    | N cycles of write-back, valid_o on the first
//
// DRAIN_CYCLES must lie in 1..DRAIN_MAX.
module rdata_handler
  import rdata_handler_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2 * SYS_ARRAY_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  addr_t                      addr_a_i,
  input  addr_t                      addr_b_i,
  input  addr_t                      addr_c_i,
  output logic                       ready_o,
  output logic                       en_a_o,
  output addr_t                      addr_a_o,
  input  row_t                       rdata_a_i,
  output logic                       en_b_o,
  output addr_t                      addr_b_o,
  input  row_t                       rdata_b_i,
  output data_t [SYS_ARRAY_SIZE-1:0] a_o,
  output data_t [SYS_ARRAY_SIZE-1:0] b_o,
  output logic                       clear_o,
  output logic                       wb_o,
  output logic                       valid_o,
  output addr_t                      addr_c_o
);

  rd_state_t state_q, state_d;
  countn_t   count_q, count_d;
  countn_t   fetch_idx;
  addr_t     base_a_q, base_b_q, base_c_q;
  logic      latch;
  logic      fetch_en;
  logic      rd_valid_q;
  logic      bubble;

  data_t [SYS_ARRAY_SIZE-1:0] row_a;
  data_t [SYS_ARRAY_SIZE-1:0] row_b;

  // Fetch index counts up while the counter counts down.
  assign fetch_idx = countn_t'(SYS_ARRAY_SIZE - 1) - count_q;

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    latch    = 1'b0;
    ready_o  = 1'b0;
    fetch_en = 1'b0;
    addr_a_o = '0;
    addr_b_o = '0;
    clear_o  = 1'b0;
    wb_o     = 1'b0;
    valid_o  = 1'b0;
    addr_c_o = '0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          latch   = 1'b1;
          count_d = countn_t'(SYS_ARRAY_SIZE - 1);
          state_d = FETCH;
        end
      end

      FETCH: begin
        fetch_en = 1'b1;
        addr_a_o = row_addr(base_a_q, fetch_idx);
        addr_b_o = row_addr(base_b_q, fetch_idx);
        clear_o  = (count_q == countn_t'(SYS_ARRAY_SIZE - 1));
        if (count_q == '0) begin
          count_d = countn_t'(DRAIN_CYCLES - 1);
          state_d = DRAIN;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      DRAIN: begin
        if (count_q == '0) begin
          count_d = countn_t'(SYS_ARRAY_SIZE - 1);
          state_d = WB;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      WB: begin
        wb_o     = 1'b1;
        addr_c_o = base_c_q;
        valid_o  = (count_q == countn_t'(SYS_ARRAY_SIZE - 1));
        if (count_q == '0) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign en_a_o = fetch_en;
  assign en_b_o = fetch_en;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Job base addresses, captured only when a job is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
    end else if (latch) begin
      base_a_q <= addr_a_i;
      base_b_q <= addr_b_i;
      base_c_q <= addr_c_i;
    end
  end

  // Read data is valid the cycle after an enabled read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_valid_q <= 1'b0;
    else        rd_valid_q <= fetch_en;
  end

  assign bubble = !rd_valid_q;
  assign row_a  = rdata_a_i;
  assign row_b  = rdata_b_i;

  skew_buffer #(
    .LANES (SYS_ARRAY_SIZE),
    .WIDTH (DATA_WIDTH)
  ) u_skew_a (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .bubble (bubble),
    .din    (row_a),
    .dout   (a_o)
  );

  skew_buffer #(
    .LANES (SYS_ARRAY_SIZE),
    .WIDTH (DATA_WIDTH)
  ) u_skew_b (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .bubble (bubble),
    .din    (row_b),
    .dout   (b_o)
  );

endmodule

// File: tb/tb_rdata_handler.sv
// Self-checking bench for rdata_handler: a cycle-indexed job model, a
// table of directed jobs, random jobs and hand-written reset/start cases.
module tb_rdata_handler;
  import rdata_handler_pkg::*;

  localparam int N        = SYS_ARRAY_SIZE;
  localparam int DW       = DATA_WIDTH;
  localparam int DRAIN    = 2 * N;
  localparam int WB_FIRST = 1 + N + DRAIN;
  localparam int JOB_LEN  = 1 + N + DRAIN + N;
  localparam int IDLE_C   = 1000;

  logic  clk_i = 1'b0;
  logic  rst_i;
  logic  start_i;
  addr_t addr_a_i, addr_b_i, addr_c_i;
  logic  ready_o, en_a_o, en_b_o, clear_o, wb_o, valid_o;
  addr_t addr_a_o, addr_b_o, addr_c_o;
  row_t  rdata_a_i, rdata_b_i;
  data_t [N-1:0] a_o, b_o;

  int checks   = 0;
  int failures = 0;

  rdata_handler dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .addr_a_i  (addr_a_i),
    .addr_b_i  (addr_b_i),
    .addr_c_i  (addr_c_i),
    .ready_o   (ready_o),
    .en_a_o    (en_a_o),
    .addr_a_o  (addr_a_o),
    .rdata_a_i (rdata_a_i),
    .en_b_o    (en_b_o),
    .addr_b_o  (addr_b_o),
    .rdata_b_i (rdata_b_i),
    .a_o       (a_o),
    .b_o       (b_o),
    .clear_o   (clear_o),
    .wb_o      (wb_o),
    .valid_o   (valid_o),
    .addr_c_o  (addr_c_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents are a pure function of the row address and lane.
  function automatic logic [31:0] mem_a(addr_t ad, int i);
    return 32'(ad) + 32'(i);
  endfunction

  function automatic logic [31:0] mem_b(addr_t ad, int i);
    return 32'hB000_0000 | (32'(ad) + 32'(i));
  endfunction

  // Synchronous read ports; unread cycles return junk to expose missing zero-fill.
  always @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      rdata_a_i[i*DW +: DW] <= en_a_o ? mem_a(addr_a_o, i) : $urandom();
      rdata_b_i[i*DW +: DW] <= en_b_o ? mem_b(addr_b_o, i) : $urandom();
    end
  end

  typedef struct {
    logic  ready, en, clear, wb, valid;
    addr_t addr_a, addr_b, addr_c;
    row_t  a, b;
  } exp_t;

  // Expected outputs in cycle c of a job (c<1 or c>=JOB_LEN means idle).
  function automatic exp_t model(int c, addr_t ba, addr_t bb, addr_t bc);
    exp_t e;
    e.ready  = (c < 1) || (c >= JOB_LEN);
    e.en     = (c >= 1) && (c <= N);
    e.addr_a = e.en ? addr_t'(32'(ba) + 32'(16 * (c - 1))) : '0;
    e.addr_b = e.en ? addr_t'(32'(bb) + 32'(16 * (c - 1))) : '0;
    e.clear  = (c == 1);
    e.wb     = (c >= WB_FIRST) && (c < WB_FIRST + N);
    e.valid  = (c == WB_FIRST);
    e.addr_c = e.wb ? bc : '0;
    e.a      = '0;
    e.b      = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = c - 2 - i;
      if (k >= 0 && k < N) begin
        e.a[i*DW +: DW] = mem_a(addr_t'(32'(ba) + 32'(16 * k)), i);
        e.b[i*DW +: DW] = mem_b(addr_t'(32'(bb) + 32'(16 * k)), i);
      end
    end
    return e;
  endfunction

  task automatic chk(string name, row_t act, row_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(exp_t e, string tag);
    chk({tag, " ready"},  row_t'(ready_o),  row_t'(e.ready));
    chk({tag, " en_a"},   row_t'(en_a_o),   row_t'(e.en));
    chk({tag, " en_b"},   row_t'(en_b_o),   row_t'(e.en));
    chk({tag, " addr_a"}, row_t'(addr_a_o), row_t'(e.addr_a));
    chk({tag, " addr_b"}, row_t'(addr_b_o), row_t'(e.addr_b));
    chk({tag, " clear"},  row_t'(clear_o),  row_t'(e.clear));
    chk({tag, " wb"},     row_t'(wb_o),     row_t'(e.wb));
    chk({tag, " valid"},  row_t'(valid_o),  row_t'(e.valid));
    chk({tag, " addr_c"}, row_t'(addr_c_o), row_t'(e.addr_c));
    chk({tag, " a_o"},    row_t'(a_o),      e.a);
    chk({tag, " b_o"},    row_t'(b_o),      e.b);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(addr_t a, addr_t b, addr_t c);
    start_i  = 1'b1;
    addr_a_i = a;
    addr_b_i = b;
    addr_c_i = c;
    tick();
    start_i  = 1'b0;
  endtask

  // Check cycles first..last of a job; noisy toggles start/addresses mid-job.
  task automatic check_job(addr_t ba, addr_t bb, addr_t bc, int first, int last,
                           bit noisy, string tag);
    for (int c = first; c <= last; c++) begin
      compare(model(c, ba, bb, bc), $sformatf("%s c%0d", tag, c));
      if (noisy) begin
        start_i  = (c < JOB_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        addr_a_i = addr_t'($urandom());
        addr_b_i = addr_t'($urandom());
        addr_c_i = addr_t'($urandom());
      end
      tick();
    end
    start_i = 1'b0;
  endtask

  task automatic idle_cycles(int n, string tag);
    for (int c = 0; c < n; c++) begin
      compare(model(IDLE_C, '0, '0, '0), $sformatf("%s i%0d", tag, c));
      tick();
    end
  endtask

  typedef struct {
    addr_t a, b, c;
    addr_t a1_exp, b1_exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    addr_t ra, rb, rc;

    tbl[0] = '{a: 16'h0100, b: 16'h0200, c: 16'h0300, a1_exp: 16'h0110, b1_exp: 16'h0210};
    tbl[1] = '{a: 16'h0000, b: 16'h0800, c: 16'h0ABC, a1_exp: 16'h0010, b1_exp: 16'h0810};
    tbl[2] = '{a: 16'hFFF0, b: 16'hFFF8, c: 16'hFFFF, a1_exp: 16'h0000, b1_exp: 16'h0008};

    rst_i    = 1'b0;
    start_i  = 1'b0;
    addr_a_i = '0;
    addr_b_i = '0;
    addr_c_i = '0;

    #2;
    compare(model(IDLE_C, '0, '0, '0), "reset");
    #10;
    rst_i = 1'b1;
    tick();
    idle_cycles(20, "idle");

    // Directed jobs from the table.
    for (int t = 0; t < 3; t++) begin
      launch(tbl[t].a, tbl[t].b, tbl[t].c);
      check_job(tbl[t].a, tbl[t].b, tbl[t].c, 1, 1, 1'b0, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d addr_a k1", t), row_t'(addr_a_o), row_t'(tbl[t].a1_exp));
      chk($sformatf("tbl%0d addr_b k1", t), row_t'(addr_b_o), row_t'(tbl[t].b1_exp));
      check_job(tbl[t].a, tbl[t].b, tbl[t].c, 2, JOB_LEN, 1'b0, $sformatf("tbl%0d", t));
      idle_cycles(2, $sformatf("tbl%0d post", t));
    end

    // start_i held high: second job only accepted on the ready edge.
    launch(16'h0400, 16'h0500, 16'h0600);
    start_i  = 1'b1;
    addr_a_i = 16'h0700;
    addr_b_i = 16'h0800;
    addr_c_i = 16'h0900;
    check_job(16'h0400, 16'h0500, 16'h0600, 1, JOB_LEN, 1'b0, "held1");
    start_i = 1'b0;
    check_job(16'h0700, 16'h0800, 16'h0900, 1, JOB_LEN, 1'b0, "held2");
    idle_cycles(2, "held post");

    // Random jobs with start/address noise while busy.
    for (int r = 0; r < 6; r++) begin
      ra = addr_t'($urandom());
      rb = addr_t'($urandom());
      rc = addr_t'($urandom());
      idle_cycles(int'($urandom_range(0, 3)), $sformatf("rnd%0d gap", r));
      launch(ra, rb, rc);
      check_job(ra, rb, rc, 1, JOB_LEN, 1'b1, $sformatf("rnd%0d", r));
    end

    // Reset in cycle 3 aborts the job asynchronously.
    launch(16'h1000, 16'h2000, 16'h3000);
    check_job(16'h1000, 16'h2000, 16'h3000, 1, 2, 1'b0, "abort");
    compare(model(3, 16'h1000, 16'h2000, 16'h3000), "abort c3");
    #2;
    rst_i = 1'b0;
    #1;
    compare(model(IDLE_C, '0, '0, '0), "async rst");
    tick();
    tick();
    rst_i = 1'b1;
    idle_cycles(JOB_LEN + 4, "after abort");
    launch(16'h4000, 16'h5000, 16'h6000);
    check_job(16'h4000, 16'h5000, 16'h6000, 1, JOB_LEN, 1'b0, "recover");
    idle_cycles(2, "end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rdata_handler.md
Name: rdata_handler

Overview:
- Read-side counterpart of the result write path.
- Accepts a job command with base addresses of A, B and C.
- Fetches SYS_ARRAY_SIZE rows of A (column-major: one memory row = one column of A) and of B (row-major) over two read ports, skews them onto the systolic-array edges, and waits for the array to drain.
- Then pulses valid with the C base address to the write data handler and holds the array in write-back for SYS_ARRAY_SIZE cycles.

Parameters:
- DRAIN_CYCLES, default 2*SYS_ARRAY_SIZE: cycles after the last fetch until array results are final.
- From common_pkg, not overridable here: SYS_ARRAY_SIZE (N, 4), DATA_WIDTH (32), ROW_BITS (N*DATA_WIDTH), ROW_BYTES (ROW_BITS/8 = 16), ADDR_WIDTH.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  job request.
- addr_a_i  in  ADDR_WIDTH  A base address.
- addr_b_i  in  ADDR_WIDTH  B base address.
- addr_c_i  in  ADDR_WIDTH  C base address.
- ready_o  out  1  high only in IDLE.
- en_a_o  out  1  A read enable.
- addr_a_o  out  ADDR_WIDTH  A read address.
- rdata_a_i  in  ROW_BITS  A read data, one cycle after en_a_o.
- en_b_o  out  1  B read enable.
- addr_b_o  out  ADDR_WIDTH  B read address.
- rdata_b_i  in  ROW_BITS  B read data, one cycle after en_b_o.
- a_o  out  data_t[N-1:0]  skewed A edge into the array.
- b_o  out  data_t[N-1:0]  skewed B edge into the array.
- clear_o  out  1  array accumulator clear.
- wb_o  out  1  array shifts out one C row per cycle.
- valid_o  out  1  to the write handler's valid_i.
- addr_c_o  out  ADDR_WIDTH  to the write handler's addr_c_i.

Behaviour:
- Reset (rst_i=0, async): state IDLE; counters 0; latched addresses 0; skew registers 0.
  - Outputs: ready_o=1; en_a_o, en_b_o, clear_o, wb_o, valid_o = 0; addresses 0; a_o, b_o = 0.
- Reset mid-job aborts immediately. No valid_o is produced for the aborted job.
- FSM states: IDLE, FETCH, DRAIN, WB. Let edge 0 be the edge that samples start_i=1 in IDLE.
- IDLE:
  - ready_o=1.
  - start_i=1 latches addr_a_i, addr_b_i, addr_c_i and loads count=N-1; next state FETCH.
  - start_i in any other state is ignored (no queueing).
- FETCH (cycles 1..N):
  - en_a_o=en_b_o=1.
  - In fetch cycle k (k=0..N-1): addr_a_o = A base + k*ROW_BYTES; same rule for B.
  - clear_o=1 in cycle 1 only.
  - At count==0 go to DRAIN and load count=DRAIN_CYCLES-1.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; wrap is silent.
- Skew:
  - rdata of read k is captured in cycle k+2.
  - Element i of A row k appears on a_o[i] in cycle k+2+i; same rule for b_o[j].
  - Lanes carry 0 whenever no fetched data occupies that slot, including before the first and after the last row.
- DRAIN: outputs idle. At count==0 go to WB and load count=N-1.
- WB:
  - wb_o=1 for N cycles.
  - valid_o=1 in the first WB cycle only, with addr_c_o = latched C base.
  - addr_c_o holds the latched value for the whole WB state; it is 0 in IDLE.
  - At count==0 go to IDLE. ready_o rises the following cycle.
- Job length, edge 0 to ready_o=1: 1+N+DRAIN_CYCLES+N cycles (17 with defaults).
- The read enables are never active outside FETCH.

Decomposition:
- common_pkg additions:
  - rd_state_t enum (IDLE/FETCH/DRAIN/WB).
  - countn_t, reused, sized for max(N, DRAIN_CYCLES).
  - ROW_BYTES (already present).
- Sub-module skew_buffer: a generic triangular delay line. Lane i has i registers, async active-low reset, and a bubble zero-fill input. It is instantiated twice, once for A and once for B.

Test Plan:
- Reset then idle: no start -> ready_o=1; en_a_o, en_b_o, valid_o, wb_o, a_o, b_o all 0 for 20 cycles.
- Single job, A=0x100, B=0x200, C=0x300:
  - addr_a_o = 0x100, 0x110, 0x120, 0x130 in cycles 1-4; addr_b_o = 0x200…0x230 in the same cycles.
  - clear_o high in cycle 1.
  - valid_o high exactly once, in cycle 13, with addr_c_o=0x300.
  - wb_o high in cycles 13-16; ready_o high from cycle 17.
- Skew check: A rows = {k*16+i} -> a_o[i]==k*16+i in cycle k+2+i, and 0 outside those slots; same for b_o.
- start_i held high throughout -> second job accepted only at cycle 17 edge; no overlap of FETCH with WB.
- Address wrap: A base = 2^ADDR_WIDTH-16 -> second fetch address 0.
- rst_i low in cycle 3 (mid-FETCH) -> all outputs 0 asynchronously, no valid_o afterwards; a new job after release completes normally.
